// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed scan controller for a 4-digit seven-segment display.
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   wr_en/wr_addr/      - write one digit {wr_dp, wr_data} into the shadow register file
//   wr_data/wr_dp
//   digit_en            - per-digit enable mask
//   brightness          - PWM duty within the ON phase (15 = full on)
//   lzb_en              - leading-zero blanking enable
//   bcd_out/dp_out      - current digit value and decimal point for the shared decoder
//   an                  - active-low one-hot anode select (4'b1111 = all off)
//   frame_tick          - one-cycle pulse on the first cycle of slot 0
module disp_scan_ctrl #(
    parameter int CLK_DIV   = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    input  logic [3:0] digit_en,
    input  logic [3:0] brightness,
    input  logic       lzb_en,
    output logic [3:0] bcd_out,
    output logic       dp_out,
    output logic [3:0] an,
    output logic       frame_tick
);
    localparam logic [15:0] SLOT_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] BLANK     = 16'(BLANK_CYC);

    logic [4:0]  shadow  [4];
    logic [4:0]  display [4];
    logic [4:0]  disp_nx [4];
    logic [1:0]  idx, idx_nx;
    logic [15:0] slot_cnt, slot_nx, phase;
    logic        slot_last, wrap, lit;
    logic [3:0]  zero, sup;

    // Everything below is the next-state view, so registered outputs line up
    // with the idx/slot_cnt they will be shown alongside.
    always_comb begin
        slot_last = slot_cnt == SLOT_LAST;
        wrap      = slot_last && idx == 2'd3;
        slot_nx   = slot_last ? 16'd0 : slot_cnt + 16'd1;
        idx_nx    = slot_last ? idx + 2'd1 : idx;
        for (int k = 0; k < 4; k++) begin
            // The frame copy takes shadow as it was before this edge's write.
            disp_nx[k] = wrap ? shadow[k] : display[k];
            zero[k]    = disp_nx[k][3:0] == 4'd0;
        end
        // A digit is a leading zero when it and every more significant digit are zero.
        sup   = lzb_en ? {zero[3], &zero[3:2], &zero[3:1], 1'b0} : 4'd0;
        // PWM position within the ON phase is the low nibble of the offset past blanking.
        phase = slot_nx - BLANK;
        lit   = slot_nx >= BLANK && phase[3:0] <= brightness;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                shadow[k]  <= 5'd0;
                display[k] <= 5'd0;
            end
            idx        <= 2'd0;
            slot_cnt   <= 16'd0;
            an         <= 4'b1111;
            bcd_out    <= 4'd0;
            dp_out     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++)
                display[k] <= disp_nx[k];
            if (wr_en)
                shadow[wr_addr] <= {wr_dp, wr_data};
            slot_cnt   <= slot_nx;
            idx        <= idx_nx;
            an         <= (lit && digit_en[idx_nx] && !sup[idx_nx]) ? ~(4'b0001 << idx_nx) : 4'b1111;
            bcd_out    <= disp_nx[idx_nx][3:0];
            dp_out     <= disp_nx[idx_nx][4];
            frame_tick <= wrap;
        end
    end
endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit seven-segment display. It holds the four BCD digit values and decimal points in a double-buffered register file. It sequences digit selection with a programmable slot period, an anti-ghosting blank interval and PWM brightness control, and applies leading-zero blanking. It drives a single shared BCD-to-7-segment decoder through bcd_out/dp_out, plus the active-low anode lines an.

Parameters:
CLK_DIV, 1000, clock cycles per digit slot; legal range BLANK_CYC+16 <= CLK_DIV <= 65535.
BLANK_CYC, 16, cycles at the start of each slot during which all anodes are off; >= 1.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active-low
wr_en  input  1  write strobe, one digit per cycle
wr_addr  input  2  digit index, 0 = least significant, 3 = most significant
wr_data  input  4  BCD value for digit wr_addr
wr_dp  input  1  decimal point for digit wr_addr
digit_en  input  4  per-digit enable, bit k gates digit k
brightness  input  4  PWM duty; 15 = full on
lzb_en  input  1  leading-zero blanking enable
bcd_out  output  4  digit value to shared decoder
dp_out  output  1  decimal point of current digit
an  output  4  anode select, active-low one-hot, 4'b1111 = all off
frame_tick  output  1  one-cycle pulse at each frame start (slot 0 begins)

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - an=4'b1111, bcd_out=0, dp_out=0, frame_tick=0.
  - Shadow and display registers cleared to 0.
  - idx=0, slot_cnt=0.
- Write path:
  - On any edge with wr_en=1, shadow[wr_addr] <= {wr_dp, wr_data}.
  - No handshake; back-to-back writes are allowed. A repeated address keeps the last value.
- Frame copy:
  - At the edge where idx wraps 3->0, display <= shadow, using shadow contents from before that edge.
  - A write on that same edge lands in shadow and is displayed in the following frame.
  - The display never shows a partially updated value within a frame.
- Scan counters:
  - slot_cnt counts 0..CLK_DIV-1.
  - At the edge where slot_cnt=CLK_DIV-1: slot_cnt <= 0 and idx <= idx+1, with idx wrapping 3->0.
  - Frame period is 4*CLK_DIV cycles.
  - Disabled or blanked digits still consume their full slot; slots are never skipped.
- Slot phases, evaluated on current state:
  - BLANK when slot_cnt < BLANK_CYC.
  - ON when slot_cnt >= BLANK_CYC.
  - Within ON, p = (slot_cnt-BLANK_CYC) mod 16. The digit is lit when p <= brightness.
- Leading-zero blanking, when lzb_en=1:
  - Digit k (k=1..3) is suppressed when display[k].data==0 and display[j].data==0 for all j>k.
  - Digit 0 is never suppressed.
  - dp bits do not affect suppression.
- an:
  - an = ~(4'b0001<<idx) when lit AND digit_en[idx] AND not suppressed.
  - Otherwise an = 4'b1111.
- bcd_out/dp_out:
  - Always display[idx], including during BLANK and disabled slots.
  - Values 10..15 pass through unmodified.
- Output timing:
  - All outputs are registered and computed from next-state values.
  - In any cycle, outputs correspond to that cycle's idx/slot_cnt. No extra latency and no combinational glitches.
- frame_tick is high for exactly the first cycle of slot 0 (slot_cnt=0, idx=0). It is not asserted in the first frame after reset.
- digit_en, brightness and lzb_en are sampled live every cycle and take effect on the next edge.

Test Plan:
1. Reset/first slot (CLK_DIV=32, BLANK_CYC=4, brightness=15, digit_en=4'hF): assert rst_n=0 mid-clock -> an=4'b1111, bcd_out=0, frame_tick=0 immediately. Release -> an=1111 for slot_cnt 0..3, then an=1110 for slot_cnt 4..31.
2. Double buffering: write digits 0..3 = 1,2,3,4 during slot 1 -> bcd_out stays 0 for the rest of the frame. After frame_tick, slots show bcd_out 1,2,3,4 with an 1110,1101,1011,0111, each for 32 cycles. frame_tick repeats every 128 cycles.
3. Leading-zero blanking: digits 3..0 = 0,0,7,0 with lzb_en=1 -> an=1111 during slots 3 and 2; slots 1 and 0 lit. With lzb_en=0 -> all four slots lit.
4. PWM: brightness=3 -> lit only at slot_cnt 4..7 and 20..23, 8 of 32 cycles. brightness=0 -> lit only at slot_cnt 4 and 20.
5. Enable mask: digit_en=4'b1011 -> an=1111 for the whole slot 2. Other slots unchanged; frame_tick period still 128.
6. Edge cases:
   - Write on the wrap edge: write addr 0 = 9 at the edge idx 3->0 -> the old value is shown this frame, 9 the next.
   - Async reset mid-slot 2 -> an=1111 at once. After release, scanning restarts at slot 0 with bcd_out=0.
